// File: rtl/spike_packet_dispatcher_if.sv
// Configuration write port and outgoing packet handshake of the spike dispatcher.
// The dispatcher is the packet source (master); the consumer/configurator is the slave.
interface spike_packet_dispatcher_if #(
    parameter int ADDR_W = 12,
    parameter int PTR_W  = 6
);
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [PTR_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_data;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [2*ADDR_W-1:0] pkt_data;

    modport master (
        input  cfg_we, cfg_sel, cfg_idx, cfg_data, pkt_ready,
        output pkt_valid, pkt_data
    );

    modport slave (
        output cfg_we, cfg_sel, cfg_idx, cfg_data, pkt_ready,
        input  pkt_valid, pkt_data
    );
endinterface

// File: rtl/spike_packet_dispatcher.sv
// Turns a sampled spike vector into a stream of {origin, destination} packets,
// walking a CSR connection table and serving spiking neurons round-robin.
module spike_packet_dispatcher #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12,
    parameter int CONN_DEPTH  = 32,
    localparam int PTR_W      = $clog2(CONN_DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   clear,
    input  logic                   step,
    input  logic [NUM_NEURONS-1:0] spikes,
    spike_packet_dispatcher_if.master bus,
    output logic                   busy,
    output logic                   overrun
);
    localparam int CUR_W = $clog2(NUM_NEURONS + 1);
    localparam int DS_W  = $clog2(CONN_DEPTH);
    localparam logic [CUR_W-1:0] LAST_NRN = CUR_W'(NUM_NEURONS - 1);
    localparam logic [PTR_W-1:0] NRN_CNT  = PTR_W'(NUM_NEURONS);
    localparam logic [PTR_W-1:0] DEPTH    = PTR_W'(CONN_DEPTH);

    typedef enum logic [1:0] {IDLE, ARB, EMIT} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0]      nrn_addr   [NUM_NEURONS];
    logic [PTR_W-1:0]       conn_ptr   [NUM_NEURONS+1];
    logic [ADDR_W-1:0]      downstream [CONN_DEPTH];
    logic [NUM_NEURONS-1:0] pending, pick_mask, cur_mask;
    logic [CUR_W-1:0]       rr_ptr, cur, pick, pick_wrap, cur_wrap;
    logic [PTR_W-1:0]       ptr, end_ptr, lo, hi_raw, hi, ptr_inc;
    logic                   has_fanout, more, xfer;

    // Lowest set bit at or after start; falls back to the lowest set bit overall (wrap).
    function automatic logic [CUR_W-1:0] first_from(input logic [NUM_NEURONS-1:0] pend,
                                                    input logic [CUR_W-1:0] start);
        logic [CUR_W-1:0] res;
        res = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--)
            if (pend[i]) res = CUR_W'(i);
        for (int i = NUM_NEURONS - 1; i >= 0; i--)
            if (pend[i] && CUR_W'(i) >= start) res = CUR_W'(i);
        return res;
    endfunction

    always_comb begin
        pick       = first_from(pending, rr_ptr);
        pick_wrap  = (pick == LAST_NRN) ? '0 : pick + 1'b1;
        cur_wrap   = (cur == LAST_NRN) ? '0 : cur + 1'b1;
        pick_mask  = NUM_NEURONS'(1) << pick;
        cur_mask   = NUM_NEURONS'(1) << cur;
        lo         = conn_ptr[pick];
        hi_raw     = conn_ptr[pick + 1'b1];
        hi         = (hi_raw > DEPTH) ? DEPTH : hi_raw;
        has_fanout = hi > lo;
        ptr_inc    = ptr + 1'b1;
        more       = ptr_inc < end_ptr;
        xfer       = (state == EMIT) && bus.pkt_ready;
    end

    always_ff @(posedge CLK or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (step && |spikes) state_nxt = ARB;
            ARB: begin
                if (has_fanout)                  state_nxt = EMIT;
                else if (|(pending & ~pick_mask)) state_nxt = ARB;
                else                             state_nxt = IDLE;
            end
            EMIT: if (xfer && !more) state_nxt = (|(pending & ~cur_mask)) ? ARB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge CLK or negedge clear) begin
        if (!clear) begin
            pending       <= '0;
            rr_ptr        <= '0;
            cur           <= '0;
            ptr           <= '0;
            end_ptr       <= '0;
            overrun       <= 1'b0;
            bus.pkt_valid <= 1'b0;
            bus.pkt_data  <= '0;
            for (int i = 0; i < NUM_NEURONS; i++)     nrn_addr[i]   <= '0;
            for (int i = 0; i < NUM_NEURONS + 1; i++) conn_ptr[i]   <= '0;
            for (int i = 0; i < CONN_DEPTH; i++)      downstream[i] <= '0;
        end else begin
            // A step that lands outside IDLE (including the final transfer) is dropped.
            if (step && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (step) pending <= spikes;
                    if (bus.cfg_we) begin
                        case (bus.cfg_sel)
                            2'd0: if (bus.cfg_idx < NRN_CNT)
                                nrn_addr[bus.cfg_idx[CUR_W-1:0]] <= bus.cfg_data;
                            2'd1: if (bus.cfg_idx <= NRN_CNT)
                                conn_ptr[bus.cfg_idx[CUR_W-1:0]] <= bus.cfg_data[PTR_W-1:0];
                            2'd2: if (bus.cfg_idx < DEPTH)
                                downstream[bus.cfg_idx[DS_W-1:0]] <= bus.cfg_data;
                            default: ;
                        endcase
                    end
                end
                ARB: begin
                    cur     <= pick;
                    ptr     <= lo;
                    end_ptr <= hi;
                    if (has_fanout) begin
                        bus.pkt_valid <= 1'b1;
                        bus.pkt_data  <= {nrn_addr[pick], downstream[lo[DS_W-1:0]]};
                    end else begin
                        pending <= pending & ~pick_mask;
                        rr_ptr  <= pick_wrap;
                    end
                end
                EMIT: begin
                    if (bus.pkt_ready) begin
                        if (more) begin
                            ptr          <= ptr_inc;
                            bus.pkt_data <= {nrn_addr[cur], downstream[ptr_inc[DS_W-1:0]]};
                        end else begin
                            bus.pkt_valid <= 1'b0;
                            pending       <= pending & ~cur_mask;
                            rr_ptr        <= cur_wrap;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_packet_dispatcher.sv
// Directed bench for spike_packet_dispatcher: latency, stall, round-robin,
// empty fanout, overrun and mid-burst reset scenarios.
module tb_spike_packet_dispatcher;
    localparam int NN = 10;
    localparam int AW = 12;
    localparam int CD = 32;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          clear = 1'b0;
    logic          step = 1'b0;
    logic [NN-1:0] spikes = '0;
    logic          busy;
    logic          overrun;

    spike_packet_dispatcher_if #(.ADDR_W(AW), .PTR_W(PW)) bus();

    spike_packet_dispatcher #(.NUM_NEURONS(NN), .ADDR_W(AW), .CONN_DEPTH(CD)) dut (
        .CLK(CLK), .clear(clear), .step(step), .spikes(spikes),
        .bus(bus), .busy(busy), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad = 0;
    logic [23:0] got [16];
    int          got_n;
    bit          timed_out;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [PW-1:0] idx, input logic [AW-1:0] data);
        bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_idx = idx; bus.cfg_data = data;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        clear = 1'b0; step = 1'b0; spikes = '0; bus.cfg_we = 1'b0; bus.pkt_ready = 1'b1;
        tick(); tick();
        clear = 1'b1;
        tick();
    endtask

    task automatic config_fanout();
        cfg_write(2'd0, 6'd2, 12'h002);
        cfg_write(2'd1, 6'd2, 12'd0);
        cfg_write(2'd1, 6'd3, 12'd3);
        cfg_write(2'd2, 6'd0, 12'h010);
        cfg_write(2'd2, 6'd1, 12'h011);
        cfg_write(2'd2, 6'd2, 12'h012);
        cfg_write(2'd2, 6'd32, 12'hBAD);   // out of range, must not alias entry 0
    endtask

    task automatic run_step(input logic [NN-1:0] vec);
        spikes = vec; step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    // Records accepted packets until the block is idle; optionally pulses step at a given packet.
    task automatic collect(input int inject_at, input logic [NN-1:0] inject_vec);
        got_n = 0; timed_out = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step = bus.pkt_valid && (got_n == inject_at);
            if (step) spikes = inject_vec;
            if (bus.pkt_valid && bus.pkt_ready) begin
                if (got_n < 16) got[got_n] = bus.pkt_data;
                got_n++;
            end
            if (!busy && !bus.pkt_valid) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        step = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.pkt_valid); end
        total++; if (bus.pkt_data !== 24'h0) begin bad++; $display("FAIL reset_data: got %h want 000000", bus.pkt_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_fanout();
        logic [23:0] exp [3];
        exp[0] = 24'h002010; exp[1] = 24'h002011; exp[2] = 24'h002012;
        config_fanout();
        bus.pkt_ready = 1'b1;
        run_step(10'h004);
        total++; if (busy !== 1'b1 || bus.pkt_valid !== 1'b0) begin
            bad++; $display("FAIL arb_cycle: busy=%b valid=%b want busy=1 valid=0", busy, bus.pkt_valid); end
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== exp[i]) begin
                bad++; $display("FAIL fanout_pkt%0d: valid=%b data=%h want valid=1 data=%h", i, bus.pkt_valid, bus.pkt_data, exp[i]); end
            tick();
        end
        total++; if (bus.pkt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL fanout_end: valid=%b busy=%b want 0 0", bus.pkt_valid, busy); end
    endtask

    task automatic test_stall();
        bus.pkt_ready = 1'b0;
        run_step(10'h004);
        tick();
        bus.cfg_sel = 2'd2; bus.cfg_idx = 6'd1; bus.cfg_data = 12'h0EE;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 24'h002010) begin
                bad++; $display("FAIL stall_hold%0d: valid=%b data=%h want valid=1 data=002010", i, bus.pkt_valid, bus.pkt_data); end
            bus.cfg_we = (i == 0);   // write while busy must be discarded
            tick();
        end
        bus.cfg_we = 1'b0;
        bus.pkt_ready = 1'b1;
        collect(-1, '0);
        total++; if (timed_out || got_n != 3) begin
            bad++; $display("FAIL stall_count: got %0d packets (timeout=%0d) want 3", got_n, timed_out); end
        total++; if (got[0] !== 24'h002010 || got[1] !== 24'h002011 || got[2] !== 24'h002012) begin
            bad++; $display("FAIL stall_seq: got %h %h %h want 002010 002011 002012", got[0], got[1], got[2]); end
    endtask

    task automatic test_overrun_mid();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_pre: got %b want 0", overrun); end
        run_step(10'h004);
        collect(1, 10'h004);
        total++; if (timed_out || got_n != 3 || got[1] !== 24'h002011 || got[2] !== 24'h002012) begin
            bad++; $display("FAIL overrun_burst: n=%0d last=%h want n=3 last=002012", got_n, got[2]); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_mid: got %b want 1", overrun); end
        got_n = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.pkt_valid) got_n++;
            tick();
        end
        total++; if (got_n != 0 || overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_dropped: extra=%0d overrun=%b want 0 1", got_n, overrun); end
    endtask

    task automatic test_overrun_last();
        do_reset();
        config_fanout();
        run_step(10'h004);
        collect(2, 10'h004);
        total++; if (timed_out || got_n != 3) begin
            bad++; $display("FAIL overrun_last_count: got %0d want 3", got_n); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_last: got %b want 1", overrun); end
        tick(); tick();
        total++; if (bus.pkt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL overrun_last_idle: valid=%b busy=%b want 0 0", bus.pkt_valid, busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        cfg_write(2'd0, 6'd0, 12'h100);
        cfg_write(2'd0, 6'd9, 12'h109);
        cfg_write(2'd1, 6'd0, 12'd0);
        for (int i = 1; i <= 9; i++) cfg_write(2'd1, PW'(i), 12'd1);
        cfg_write(2'd1, 6'd10, 12'd2);
        cfg_write(2'd2, 6'd0, 12'h020);
        cfg_write(2'd2, 6'd1, 12'h029);
        for (int r = 0; r < 2; r++) begin
            run_step(10'h201);
            collect(-1, '0);
            total++; if (timed_out || got_n != 2 || got[0] !== 24'h100020 || got[1] !== 24'h109029) begin
                bad++; $display("FAIL rr_round%0d: n=%0d %h %h want 2 100020 109029", r, got_n, got[0], got[1]); end
        end
        run_step(10'h001);
        collect(-1, '0);
        total++; if (timed_out || got_n != 1 || got[0] !== 24'h100020) begin
            bad++; $display("FAIL rr_single: n=%0d %h want 1 100020", got_n, got[0]); end
        run_step(10'h201);
        collect(-1, '0);
        total++; if (timed_out || got_n != 2 || got[0] !== 24'h109029 || got[1] !== 24'h100020) begin
            bad++; $display("FAIL rr_fair: n=%0d %h %h want 2 109029 100020", got_n, got[0], got[1]); end
    endtask

    task automatic test_no_fanout();
        run_step(10'h008);
        total++; if (busy !== 1'b1 || bus.pkt_valid !== 1'b0) begin
            bad++; $display("FAIL nofan_arb: busy=%b valid=%b want 1 0", busy, bus.pkt_valid); end
        tick();
        total++; if (busy !== 1'b0 || bus.pkt_valid !== 1'b0) begin
            bad++; $display("FAIL nofan_idle: busy=%b valid=%b want 0 0", busy, bus.pkt_valid); end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        config_fanout();
        bus.pkt_ready = 1'b0;
        run_step(10'h004);
        tick();
        total++; if (bus.pkt_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre: valid=%b want 1", bus.pkt_valid); end
        #2 clear = 1'b0;
        #1;
        total++; if (bus.pkt_valid !== 1'b0 || busy !== 1'b0 || bus.pkt_data !== 24'h0) begin
            bad++; $display("FAIL midrst_async: valid=%b busy=%b data=%h want 0 0 000000", bus.pkt_valid, busy, bus.pkt_data); end
        tick();
        #2 clear = 1'b1;
        bus.pkt_ready = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_idx = 6'd2; bus.cfg_data = 12'h0AB;
        tick();
        bus.cfg_we = 1'b0;
        total++; if (bus.pkt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_quiet: valid=%b busy=%b want 0 0", bus.pkt_valid, busy); end
        cfg_write(2'd1, 6'd3, 12'd3);
        cfg_write(2'd2, 6'd0, 12'h010);
        cfg_write(2'd2, 6'd1, 12'h011);
        cfg_write(2'd2, 6'd2, 12'h012);
        run_step(10'h004);
        collect(-1, '0);
        total++; if (timed_out || got_n != 3 || got[0] !== 24'h0AB010 || got[2] !== 24'h0AB012) begin
            bad++; $display("FAIL midrst_cfg: n=%0d first=%h last=%h want 3 0AB010 0AB012", got_n, got[0], got[2]); end
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_idx = '0; bus.cfg_data = '0; bus.pkt_ready = 1'b1;
        test_reset();
        test_fanout();
        test_stall();
        test_overrun_mid();
        test_overrun_last();
        test_round_robin();
        test_no_fanout();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
